// File: rtl/bundle_pkg.sv
// Shared types and helpers for the HDC bundling accumulator.
// Lane encoding: a 0 bit votes +1, a 1 bit votes -1.
package bundle_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic BIT_INC = 1'b0;
    localparam logic BIT_DEC = 1'b1;

    function automatic int sat_max(input int cnt_w);
        return (1 << (cnt_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/bundle_lane.sv
// One signed saturating lane counter, symmetric limits +/-sat_max(CNT_W).
// Flags describe the value being loaded this cycle so the top can register the majority bit alongside it.
module bundle_lane
    import bundle_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic hv_bit,
    input  logic clr,
    output logic neg,
    output logic zero,
    output logic would_sat
);

    localparam logic signed [CNT_W-1:0] MAX = CNT_W'(sat_max(CNT_W));
    localparam logic signed [CNT_W-1:0] MIN = -MAX;

    logic signed [CNT_W-1:0] count;
    logic signed [CNT_W-1:0] next_count;

    always_comb begin
        next_count = count;
        would_sat  = 1'b0;
        if (en) begin
            if (hv_bit == BIT_DEC) begin
                if (count == MIN) would_sat = 1'b1;
                else              next_count = count - CNT_W'(1);
            end else begin
                if (count == MAX) would_sat = 1'b1;
                else              next_count = count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) count <= '0;
        else            count <= next_count;
    end

    assign neg  = next_count[CNT_W-1];
    assign zero = (next_count == '0);

endmodule

// File: rtl/bundle_accumulator.sv
// HDC bundling unit: accumulates hypervectors into saturating lane counters and
// emits the per-lane majority vector through a valid/ready port.
module bundle_accumulator
    import bundle_pkg::*;
#(
    parameter int DIM    = 32,
    parameter int CNT_W  = 8,
    parameter int VCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIM-1:0]    in_hv,
    input  logic              in_last,
    input  logic              clear,
    input  logic [DIM-1:0]    tie_hv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIM-1:0]    out_hv,
    output logic [VCNT_W-1:0] vec_count,
    output logic              sat
);

    localparam logic [VCNT_W-1:0] VCNT_MAX = '1;

    state_t         state;
    state_t         next_state;
    logic           accept;
    logic           done;
    logic           handshake;
    logic           lane_clr;
    logic [DIM-1:0] neg;
    logic [DIM-1:0] zero;
    logic [DIM-1:0] lane_sat;
    logic [DIM-1:0] result;

    assign in_ready  = (state == ACC) && !clear && !rst;
    assign accept    = in_valid && in_ready;
    assign done      = accept && in_last;
    assign out_valid = (state == EMIT);
    assign handshake = out_valid && out_ready;
    assign lane_clr  = clear || handshake;

    for (genvar g = 0; g < DIM; g++) begin : g_lane
        bundle_lane #(.CNT_W(CNT_W)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (accept),
            .hv_bit   (in_hv[g]),
            .clr      (lane_clr),
            .neg      (neg[g]),
            .zero     (zero[g]),
            .would_sat(lane_sat[g])
        );
    end

    always_comb begin
        result = '0;
        for (int unsigned i = 0; i < DIM; i++) begin
            if (neg[i])       result[i] = 1'b1;
            else if (zero[i]) result[i] = tie_hv[i];
        end
    end

    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = ACC;
        end else begin
            case (state)
                ACC:     if (done)      next_state = EMIT;
                EMIT:    if (out_ready) next_state = ACC;
                default: next_state = ACC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ACC;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst || lane_clr) begin
            vec_count <= '0;
            sat       <= 1'b0;
        end else if (accept) begin
            if (vec_count != VCNT_MAX) vec_count <= vec_count + VCNT_W'(1);
            if (|lane_sat)             sat       <= 1'b1;
        end
    end

    // out_hv survives clear and handshake; only reset or a new result changes it.
    always_ff @(posedge clk) begin
        if (rst)       out_hv <= '0;
        else if (done) out_hv <= result;
    end

endmodule

// File: tb/tb_bundle_accumulator.sv
// Self-checking bench for bundle_accumulator: directed scenarios plus random traffic
// compared against an integer-count reference model.
module tb_bundle_accumulator;

    localparam int DIM    = 8;
    localparam int CNT_W  = 4;
    localparam int VCNT_W = 16;
    localparam int LIM    = (1 << (CNT_W - 1)) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DIM-1:0]    in_hv = '0;
    logic              in_last = 1'b0;
    logic              clear = 1'b0;
    logic [DIM-1:0]    tie_hv = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DIM-1:0]    out_hv;
    logic [VCNT_W-1:0] vec_count;
    logic              sat;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int       m_cnt[DIM];
    bit       m_emit = 1'b0;
    bit [7:0] m_hv   = '0;
    int       m_vcnt = 0;
    bit       m_sat  = 1'b0;

    bundle_accumulator #(.DIM(DIM), .CNT_W(CNT_W), .VCNT_W(VCNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_hv    (in_hv),
        .in_last  (in_last),
        .clear    (clear),
        .tie_hv   (tie_hv),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_hv   (out_hv),
        .vec_count(vec_count),
        .sat      (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear_bundle();
        for (int i = 0; i < DIM; i++) m_cnt[i] = 0;
        m_vcnt = 0;
        m_sat  = 1'b0;
        m_emit = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit [7:0] hv, input bit l, input bit c,
                              input bit ordy, input bit [7:0] tie, input bit r);
        int nv;
        if (r) begin
            model_clear_bundle();
            m_hv = '0;
        end else if (c) begin
            model_clear_bundle();
        end else if (m_emit) begin
            if (ordy) model_clear_bundle();
        end else if (v) begin
            for (int i = 0; i < DIM; i++) begin
                nv = m_cnt[i] + (hv[i] ? -1 : 1);
                if (nv > LIM)  begin nv = LIM;  m_sat = 1'b1; end
                if (nv < -LIM) begin nv = -LIM; m_sat = 1'b1; end
                m_cnt[i] = nv;
            end
            if (m_vcnt < (1 << VCNT_W) - 1) m_vcnt++;
            if (l) begin
                for (int i = 0; i < DIM; i++)
                    m_hv[i] = (m_cnt[i] < 0) ? 1'b1 : (m_cnt[i] > 0) ? 1'b0 : tie[i];
                m_emit = 1'b1;
            end
        end
    endtask

    // Drive one cycle's inputs, check in_ready, advance the model at the edge, check outputs.
    task automatic cyc(input bit v, input bit [7:0] hv, input bit l, input bit c,
                       input bit ordy, input bit [7:0] tie, input bit r);
        in_valid = v; in_hv = hv; in_last = l; clear = c;
        out_ready = ordy; tie_hv = tie; rst = r;
        #1;
        check("in_ready", 32'(in_ready), 32'(!m_emit && !c && !r));
        @(posedge clk);
        model_step(v, hv, l, c, ordy, tie, r);
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(m_emit));
        check("out_hv",    32'(out_hv),    32'(m_hv));
        check("vec_count", 32'(vec_count), 32'(m_vcnt));
        check("sat",       32'(sat),       32'(m_sat));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit [7:0] rhv;
        for (int i = 0; i < DIM; i++) m_cnt[i] = 0;

        // reset
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_vec_count", 32'(vec_count), 32'd0);

        // 1: basic majority
        cyc(1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'h0F, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'hF0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        check("t1_hv",    32'(out_hv),    32'h0F);
        check("t1_vcnt",  32'(vec_count), 32'd3);
        check("t1_sat",   32'(sat),       32'd0);
        check("t1_valid", 32'(out_valid), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        check("t1_valid_drop", 32'(out_valid), 32'd0);

        // 2: all-tie lanes take tie_hv
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
        cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0);
        check("t2_hv",   32'(out_hv),    32'h3C);
        check("t2_vcnt", 32'(vec_count), 32'd2);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

        // 3: saturation
        for (int k = 0; k < 10; k++)
            cyc(1'b1, 8'h00, (k == 9), 1'b0, 1'b1, 8'hFF, 1'b0);
        check("t3_hv",   32'(out_hv),    32'h00);
        check("t3_sat",  32'(sat),       32'd1);
        check("t3_vcnt", 32'(vec_count), 32'd10);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        check("t3_sat_next", 32'(sat), 32'd0);
        cyc(1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        check("t3_hv_next", 32'(out_hv), 32'hC3);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

        // 4: backpressure
        cyc(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 5; k++)
            cyc(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("t4_hv_held",  32'(out_hv),    32'h33);
        check("t4_vcnt",     32'(vec_count), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        check("t4_ready_after", 32'(in_ready), 32'd1);
        cyc(1'b1, 8'h81, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        check("t4_fresh_hv", 32'(out_hv), 32'h81);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

        // 5: clear mid-bundle
        cyc(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
        cyc(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
        check("t5_hv",   32'(out_hv),    32'h00);
        check("t5_vcnt", 32'(vec_count), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

        // 6: reset while emitting
        cyc(1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("t6_valid_rst", 32'(out_valid), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        check("t6_hv", 32'(out_hv), 32'h5A);
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            rhv = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            cyc(($urandom_range(0, 9) < 7), rhv, ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6),
                8'($urandom), ($urandom_range(0, 99) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bundle_accumulator.md
# bundle_accumulator

Parametrised HDC bundling unit. Each cycle it can absorb one DIM-bit hypervector into DIM signed saturating lane counters: a 0 bit adds +1 and a 1 bit adds −1. On the last vector of a bundle it emits the per-lane majority hypervector through a valid/ready output port. It sits between the core result path and the store path and replaces the per-bit +1/0/−1 selector with full accumulation, tie-break, saturation and flow control.

## Interface
Parameters:
- DIM, 32, number of lanes (hypervector width), ≥1
- CNT_W, 8, lane counter width (signed), ≥2
- VCNT_W, 16, width of accepted-vector counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  accumulator can accept a beat
- in_hv  in  DIM  hypervector to bundle
- in_last  in  1  beat is the final vector of the bundle
- clear  in  1  discard the current bundle
- tie_hv  in  DIM  per-lane result used when the lane count is exactly 0
- out_valid  out  1  majority result valid
- out_ready  in  1  consumer accepts result
- out_hv  out  DIM  majority hypervector
- vec_count  out  VCNT_W  vectors accepted in the current or emitted bundle
- sat  out  1  sticky: some lane saturated in this bundle

## Operation
- States: ACC and EMIT. Reset state is ACC.
- Reset values: lane counters 0, out_hv 0, out_valid 0, vec_count 0, sat 0. in_ready is 0 while rst is high.
- in_ready = (state==ACC) && !clear && !rst. Combinational from state and clear only, never from in_valid.
- A beat is accepted when in_valid && in_ready. For each lane i: cnt[i] += in_hv[i] ? −1 : +1.
- Saturation is symmetric at ±(2^(CNT_W−1)−1). Counters hold at the limit. sat is set when any lane would pass the limit.
- vec_count increments on each accepted beat and saturates at 2^VCNT_W−1.
- Accepted beat with in_last: out_hv[i] is computed from the post-update count. Rule: 1 if count<0, 0 if count>0, tie_hv[i] (sampled on the same cycle) if count==0. The block then enters EMIT.
- EMIT: out_valid=1. out_hv, vec_count and sat are held stable. in_ready=0.
- Handshake out_valid && out_ready: counters, vec_count and sat are cleared, and the block returns to ACC.
- clear (any state) has priority over everything except rst. Next cycle: counters, vec_count and sat are 0, out_valid is 0, state is ACC. A beat presented with clear is not accepted, because in_ready is low.
- rst mid-bundle or mid-EMIT gives the reset values on the next cycle. A pending output is lost.

## Timing
- Beat accepted at edge t: counters are updated at t. The last beat at t gives out_valid=1 and a valid out_hv after edge t (one-cycle latency).
- Throughput: one beat per cycle in ACC. There is one dead cycle minimum per bundle: the handshake cycle, then in_ready=1 on the following cycle.
- out_valid is never dropped without a handshake, except on clear or rst.
- A single-beat bundle (in_last on the first beat) is legal. The result is the bitwise copy of in_hv, because every count is ±1.

## Structure
- Package bundle_pkg holds:
  - the state enum (ACC, EMIT)
  - the function sat_max(CNT_W) = 2^(CNT_W−1)−1
  - the lane update encoding (0→+1, 1→−1)
- Sub-module bundle_lane:
  - one signed saturating counter with inputs en, bit, clr
  - outputs: count sign/zero flags and a would-saturate flag
  - instantiated DIM times by generate
- Top level holds the FSM, vec_count, the sat OR-reduce and the out_hv register.

## Test plan
1. DIM=8, CNT_W=4. Send 0x0F, 0x0F, then 0xF0 with last; out_ready=1 → out_hv=0x0F, vec_count=3, sat=0, out_valid for one cycle.
2. Send 0xAA, then 0x55 with last; tie_hv=0x3C → all counts 0, out_hv=0x3C, vec_count=2.
3. Send 10 beats of 0x00, last on the 10th → counts held at +7, sat=1, out_hv=0x00, vec_count=10. The next bundle starts with sat=0.
4. Backpressure: hold out_ready=0 for 5 cycles after the result → out_valid, out_hv and vec_count stay stable, in_ready=0. Raise out_ready → handshake, then in_ready=1 on the next cycle with counters at 0.
5. Clear mid-bundle: send 0xFF, 0xFF, pulse clear together with in_valid and 0xFF, then send 0x00 with last → the 0xFF beat during clear is not accepted, out_hv=0x00, vec_count=1.
6. Assert rst for 1 cycle while in EMIT → out_valid=0 and counters 0 the next cycle, then in_ready=1 after rst falls. A following single-beat bundle of 0x5A gives out_hv=0x5A.
